memory_stage: RTL

- Pipeline stage between execute and writeback.
- Accepts one instruction per handshake from execute.
- For ld/str, drives a single-outstanding request/acknowledge data-memory port; all other ops pass straight through.
- Presents a registered bundle to writeback (reg number, memory data, ALU result, store value, op flags) with a one-cycle valid pulse. Writeback never back-pressures.

---
 rtl/memory_stage_pkg.sv | 35 +++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/memory_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared widths, op-flag bundle and op decode for the memory stage
package memory_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;
  localparam int ADDR_W_DEF = 16;

  // Field order here is also the writeback flag order.
  typedef struct packed {
    logic is_alu;
    logic is_cmp;
    logic is_jmp;
    logic is_ld;
    logic is_str;
  } op_flags_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_LD   = 2'd1,
    OP_STR  = 2'd2
  } op_kind_t;

  // Loads win over stores, and both win over the pass-through classes.
  function automatic op_kind_t decode_op(input op_flags_t f);
    op_kind_t k;
    k = OP_PASS;
    if (f.is_ld) begin
      k = OP_LD;
    end else if (f.is_str) begin
      k = OP_STR;
    end
    return k;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait counter; flags the cycle it reaches TIMEOUT_CYC
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Asserted in the cycle whose increment lands on the limit (or stays saturated there).
  assign expired = enable && !clear && (count_d == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - execute-to-writeback stage with a single-outstanding data-memory port
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  rd_num,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] result,
  input  logic              is_alu_op,
  input  logic              is_cmp_op,
  input  logic              is_jmp_op,
  input  logic              is_ld_op,
  input  logic              is_str_op,
  output logic              mem_req,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_val_out,
  input  logic [DATA_W-1:0] mem_val_in,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [REG_W-1:0]  rd_num_passthrough,
  output logic [DATA_W-1:0] md_passthrough,
  output logic [DATA_W-1:0] result_passthrough,
  output logic [DATA_W-1:0] rd_val_passthrough,
  output logic              is_alu_op_passthrough,
  output logic              is_cmp_op_passthrough,
  output logic              is_jmp_op_passthrough,
  output logic              is_ld_op_passthrough,
  output logic              is_str_op_passthrough,
  output logic              bus_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_val_q, mem_val_d;

  // Instruction held while the memory access is outstanding.
  logic [REG_W-1:0]  pend_rd_num_q, pend_rd_num_d;
  logic [DATA_W-1:0] pend_rd_val_q, pend_rd_val_d;
  logic [DATA_W-1:0] pend_result_q, pend_result_d;
  op_flags_t         pend_flags_q, pend_flags_d;

  logic              out_valid_q, out_valid_d;
  logic [REG_W-1:0]  wb_rd_num_q, wb_rd_num_d;
  logic [DATA_W-1:0] wb_md_q, wb_md_d;
  logic [DATA_W-1:0] wb_result_q, wb_result_d;
  logic [DATA_W-1:0] wb_rd_val_q, wb_rd_val_d;
  op_flags_t         wb_flags_q, wb_flags_d;
  logic              bus_err_q, bus_err_d;

  op_flags_t in_flags;
  op_kind_t  in_kind;
  logic      accept;
  logic      misaligned;
  logic      timer_clear;
  logic      timer_enable;
  logic      timer_expired;

  assign in_flags   = {is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op};
  assign in_kind    = decode_op(in_flags);
  assign misaligned = (result[1:0] != 2'b00);
  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;

  assign timer_enable = (state_q == ST_WAIT) && !mem_ack;

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_val_d     = mem_val_q;
    pend_rd_num_d = pend_rd_num_q;
    pend_rd_val_d = pend_rd_val_q;
    pend_result_d = pend_result_q;
    pend_flags_d  = pend_flags_q;
    out_valid_d   = 1'b0;
    wb_rd_num_d   = wb_rd_num_q;
    wb_md_d       = wb_md_q;
    wb_result_d   = wb_result_q;
    wb_rd_val_d   = wb_rd_val_q;
    wb_flags_d    = wb_flags_q;
    bus_err_d     = bus_err_q;
    timer_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((in_kind == OP_PASS) || misaligned) begin
            out_valid_d = 1'b1;
            wb_rd_num_d = rd_num;
            wb_md_d     = '0;
            wb_result_d = result;
            wb_rd_val_d = rd_val;
            wb_flags_d  = in_flags;
            bus_err_d   = (in_kind != OP_PASS);
          end else begin
            mem_req_d     = 1'b1;
            mem_we_d      = (in_kind == OP_STR);
            mem_addr_d    = result[ADDR_W+1:2];
            mem_val_d     = rd_val;
            pend_rd_num_d = rd_num;
            pend_rd_val_d = rd_val;
            pend_result_d = result;
            pend_flags_d  = in_flags;
            timer_clear   = 1'b1;
            state_d       = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // An ack arriving in the timeout cycle still completes normally.
        if (mem_ack || timer_expired) begin
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          wb_rd_num_d = pend_rd_num_q;
          wb_result_d = pend_result_q;
          wb_rd_val_d = pend_rd_val_q;
          wb_flags_d  = pend_flags_q;
          bus_err_d   = !mem_ack;
          wb_md_d     = '0;
          if (mem_ack) begin
            wb_md_d = pend_flags_q.is_ld ? mem_val_in : pend_rd_val_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_val_q     <= '0;
      pend_rd_num_q <= '0;
      pend_rd_val_q <= '0;
      pend_result_q <= '0;
      pend_flags_q  <= '0;
      out_valid_q   <= 1'b0;
      wb_rd_num_q   <= '0;
      wb_md_q       <= '0;
      wb_result_q   <= '0;
      wb_rd_val_q   <= '0;
      wb_flags_q    <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_val_q     <= mem_val_d;
      pend_rd_num_q <= pend_rd_num_d;
      pend_rd_val_q <= pend_rd_val_d;
      pend_result_q <= pend_result_d;
      pend_flags_q  <= pend_flags_d;
      out_valid_q   <= out_valid_d;
      wb_rd_num_q   <= wb_rd_num_d;
      wb_md_q       <= wb_md_d;
      wb_result_q   <= wb_result_d;
      wb_rd_val_q   <= wb_rd_val_d;
      wb_flags_q    <= wb_flags_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem_req               = mem_req_q;
  assign mem_write_en          = mem_we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_val_out           = mem_val_q;
  assign out_valid             = out_valid_q;
  assign rd_num_passthrough    = wb_rd_num_q;
  assign md_passthrough        = wb_md_q;
  assign result_passthrough    = wb_result_q;
  assign rd_val_passthrough    = wb_rd_val_q;
  assign is_alu_op_passthrough = wb_flags_q.is_alu;
  assign is_cmp_op_passthrough = wb_flags_q.is_cmp;
  assign is_jmp_op_passthrough = wb_flags_q.is_jmp;
  assign is_ld_op_passthrough  = wb_flags_q.is_ld;
  assign is_str_op_passthrough = wb_flags_q.is_str;
  assign bus_err               = bus_err_q;

endmodule
